dmem_arbiter: RTL and testbench

//  Sequences and shares the word-organised data memory between two requesters:

---
 rtl/dmem_if.sv | 17 +
 rtl/dmem_arbiter.sv | 84 ++++++++
 tb/tb_dmem_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// dmem_if: requester/memory bus for the shared data-memory arbiter.
// The slave side is the arbiter. The master side is the surrounding requesters and memory.
interface dmem_if #(parameter int DM_ADDRESS = 9);
    logic [1:0]            req, we, gnt, done, err;
    logic [2:0]            funct3_p0, funct3_p1;
    logic [DM_ADDRESS-1:0] addr_p0, addr_p1;
    logic [31:0]           wd_p0, wd_p1, rd, mem_addr, mem_wd, mem_rd;
    logic [3:0]            mem_wr;
    modport slave (
        input  req, we, funct3_p0, funct3_p1, addr_p0, addr_p1, wd_p0, wd_p1, mem_rd,
        output gnt, done, err, rd, mem_addr, mem_wd, mem_wr
    );
    modport master (
        output req, we, funct3_p0, funct3_p1, addr_p0, addr_p1, wd_p0, wd_p1, mem_rd,
        input  gnt, done, err, rd, mem_addr, mem_wd, mem_wr
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of a word-wide data memory between two ports.
// Sub-word loads are extracted here; sub-word stores use read-modify-write.
module dmem_arbiter #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input logic   clk,
    input logic   rst_n,
    dmem_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
    state_t                  r_state, w_next;
    logic                    r_rr_last, r_sel, r_we, r_err;
    logic [2:0]              r_f3;
    logic [DM_ADDRESS-1:0]   r_addr;
    logic [DATA_W-1:0]       r_word, r_rd;
    logic                    w_any, w_win, w_we, w_bad;
    logic [2:0]              w_f3;
    logic [DM_ADDRESS-1:0]   w_addr;
    logic [DM_ADDRESS-3:0]   w_widx;
    logic [DATA_W-1:0]       w_wd, w_load, w_mask, w_merge;
    logic [4:0]              w_sh;
    logic [7:0]              w_byte;
    logic [15:0]             w_half;

    always_comb begin
        w_any  = |bus.req;
        w_win  = &bus.req ? ~r_rr_last : bus.req[1];
        w_we   = bus.we[w_win];
        w_f3   = w_win ? bus.funct3_p1 : bus.funct3_p0;
        w_addr = w_win ? bus.addr_p1 : bus.addr_p0;
        w_wd   = w_win ? bus.wd_p1 : bus.wd_p0;
        w_bad  = (w_f3[1:0] == 2'b01 && w_addr[0]) || (w_f3[1:0] == 2'b10 && w_addr[1:0] != 2'b00) ||
                 w_f3[1:0] == 2'b11 || (w_we ? w_f3[2] : w_f3 == 3'b110);
        // Halves are always aligned, so the byte-lane shift also selects the half lane
        w_sh    = {r_addr[1:0], 3'b000};
        w_byte  = 8'(bus.mem_rd >> w_sh);
        w_half  = 16'(bus.mem_rd >> w_sh);
        w_load  = r_f3[1:0] == 2'b00 ? {{24{~r_f3[2] & w_byte[7]}}, w_byte} :
                  r_f3[1:0] == 2'b01 ? {{16{~r_f3[2] & w_half[15]}}, w_half} : bus.mem_rd;
        w_mask  = r_f3[0] ? DATA_W'(16'hFFFF) << w_sh : DATA_W'(8'hFF) << w_sh;
        w_merge = (bus.mem_rd & ~w_mask) | ((r_word << w_sh) & w_mask);
        w_next  = r_state == IDLE ? (!w_any ? IDLE : w_bad ? RESP : (w_we && w_f3[1:0] == 2'b10) ? WR : RD) :
                  r_state == RD   ? (r_we ? WR : RESP) :
                  r_state == WR   ? RESP : IDLE;
        w_widx  = r_state == IDLE ? (w_any ? w_addr[DM_ADDRESS-1:2] : '0) : r_addr[DM_ADDRESS-1:2];
        bus.gnt      = {2{r_state == IDLE && w_any && rst_n}} & {w_win, ~w_win};
        bus.done     = {2{r_state == RESP && rst_n}} & {r_sel, ~r_sel};
        bus.err      = bus.done & {2{r_err}};
        bus.mem_wr   = {4{r_state == WR && rst_n}};
        bus.mem_wd   = r_state == WR ? r_word : '0;
        bus.mem_addr = {{(32-DM_ADDRESS){1'b0}}, w_widx, 2'b00};
        bus.rd       = r_rd;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_rr_last <= 1'b1;
            r_sel     <= 1'b0;
            r_we      <= 1'b0;
            r_err     <= 1'b0;
            r_f3      <= '0;
            r_addr    <= '0;
            r_word    <= '0;
            r_rd      <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_any) begin
                r_sel     <= w_win;
                r_rr_last <= w_win;
                r_we      <= w_we;
                r_err     <= w_bad;
                r_f3      <= w_f3;
                r_addr    <= w_addr;
                r_word    <= w_wd;
            end
            if (r_state == RD && r_we)
                r_word <= w_merge;
            if (r_state == RD && !r_we)
                r_rd <= w_load;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed tests for dmem_arbiter against a one-cycle-latency word memory.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_if #(.DM_ADDRESS(9)) bus();
    dmem_arbiter #(.DM_ADDRESS(9), .DATA_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [31:0] mem [128];
    logic        bd_we = 1'b0;
    logic [6:0]  bd_idx = '0;
    logic [31:0] bd_data = '0;
    int checks = 0, errors = 0, wr_cnt = 0, bad_wr = 0;

    always @(posedge clk) begin
        bus.mem_rd <= mem[bus.mem_addr[8:2]];
        if (bus.mem_wr == 4'hF) mem[bus.mem_addr[8:2]] <= bus.mem_wd;
        if (bd_we) mem[bd_idx] <= bd_data;
    end

    always @(negedge clk) begin
        if (bus.mem_wr == 4'hF) wr_cnt++;
        else if (bus.mem_wr != 4'h0) bad_wr++;
    end

    task automatic poke(input logic [6:0] idx, input logic [31:0] d);
        bd_idx = idx; bd_data = d; bd_we = 1'b1;
        @(posedge clk); #1 bd_we = 1'b0;
    endtask

    task automatic set_port(input int p, input logic w, input logic [2:0] f3, input logic [8:0] a, input logic [31:0] d);
        if (p == 0) begin bus.funct3_p0 = f3; bus.addr_p0 = a; bus.wd_p0 = d; end
        else begin bus.funct3_p1 = f3; bus.addr_p1 = a; bus.wd_p1 = d; end
        bus.we[p] = w;
        bus.req[p] = 1'b1;
    endtask

    task automatic access(input int p, input logic w, input logic [2:0] f3, input logic [8:0] a,
                          input logic [31:0] d, output int lat, output logic e);
        logic g;
        g = 1'b0; lat = -1; e = 1'b0;
        set_port(p, w, f3, a, d);
        for (int i = 0; i < 20 && !g; i++) begin
            @(negedge clk);
            if (bus.gnt[p]) g = 1'b1;
        end
        @(posedge clk); #1 bus.req[p] = 1'b0;
        for (int n = 1; n <= 10 && g && lat < 0; n++) begin
            @(negedge clk);
            if (bus.done[p]) begin lat = n; e = bus.err[p]; end
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; bus.req = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.req = 2'b00;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({bus.gnt, bus.done, bus.err, bus.mem_wr} !== 10'd0 || bus.rd !== 32'd0 ||
            bus.mem_addr !== 32'd0 || bus.mem_wd !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs gnt=%b done=%b err=%b wr=%b rd=%h addr=%h wd=%h want all zero",
                     bus.gnt, bus.done, bus.err, bus.mem_wr, bus.rd, bus.mem_addr, bus.mem_wd);
        end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_lw();
        int lat, w0; logic e;
        poke(7'd4, 32'hDEADBEEF);
        w0 = wr_cnt;
        access(0, 1'b0, 3'b010, 9'h010, 32'd0, lat, e);
        checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency got %0d want 2", lat); end
        checks++; if (bus.rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rd got %h want deadbeef", bus.rd); end
        checks++; if (wr_cnt !== w0 || e !== 1'b0) begin errors++; $display("FAIL lw_no_write writes=%0d err=%b want 0 0", wr_cnt - w0, e); end
    endtask

    task automatic test_sb();
        int lat, w0; logic e;
        poke(7'd4, 32'h11223344);
        w0 = wr_cnt;
        access(0, 1'b1, 3'b000, 9'h013, 32'h000000AA, lat, e);
        checks++; if (lat !== 3) begin errors++; $display("FAIL sb_latency got %0d want 3", lat); end
        checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL sb_write_count got %0d want 1", wr_cnt - w0); end
        checks++; if (mem[4] !== 32'hAA223344) begin errors++; $display("FAIL sb_merge got %h want aa223344", mem[4]); end
    endtask

    task automatic test_lanes();
        int lat; logic e;
        poke(7'd4, 32'h00008000);
        access(0, 1'b0, 3'b000, 9'h011, 32'd0, lat, e);
        checks++; if (bus.rd !== 32'hFFFFFF80 || lat !== 2) begin errors++; $display("FAIL lb_sign got %h lat %0d want ffffff80 lat 2", bus.rd, lat); end
        access(0, 1'b0, 3'b100, 9'h011, 32'd0, lat, e);
        checks++; if (bus.rd !== 32'h00000080) begin errors++; $display("FAIL lbu_zero got %h want 00000080", bus.rd); end
        poke(7'd4, 32'h80000000);
        access(0, 1'b0, 3'b001, 9'h012, 32'd0, lat, e);
        checks++; if (bus.rd !== 32'hFFFF8000) begin errors++; $display("FAIL lh_sign got %h want ffff8000", bus.rd); end
        access(0, 1'b0, 3'b101, 9'h012, 32'd0, lat, e);
        checks++; if (bus.rd !== 32'h00008000) begin errors++; $display("FAIL lhu_zero got %h want 00008000", bus.rd); end
        access(1, 1'b1, 3'b010, 9'h024, 32'h12345678, lat, e);
        checks++; if (mem[9] !== 32'h12345678 || lat !== 2) begin errors++; $display("FAIL sw_p1 got %h lat %0d want 12345678 lat 2", mem[9], lat); end
        access(0, 1'b1, 3'b001, 9'h026, 32'h0000BEEF, lat, e);
        checks++; if (mem[9] !== 32'hBEEF5678 || lat !== 3) begin errors++; $display("FAIL sh_merge got %h lat %0d want beef5678 lat 3", mem[9], lat); end
        checks++; if (bus.rd !== 32'h00008000) begin errors++; $display("FAIL rd_hold got %h want 00008000", bus.rd); end
    endtask

    task automatic test_err();
        int lat, w0; logic e;
        poke(7'd0, 32'hCAFEF00D);
        w0 = wr_cnt;
        access(0, 1'b1, 3'b001, 9'h001, 32'h00001234, lat, e);
        checks++; if (lat !== 1 || e !== 1'b1) begin errors++; $display("FAIL sh_misaligned lat %0d err %b want lat 1 err 1", lat, e); end
        checks++; if (wr_cnt !== w0 || mem[0] !== 32'hCAFEF00D) begin errors++; $display("FAIL sh_misaligned_mem writes %0d word %h want 0 cafef00d", wr_cnt - w0, mem[0]); end
        access(1, 1'b0, 3'b011, 9'h004, 32'd0, lat, e);
        checks++; if (lat !== 1 || e !== 1'b1) begin errors++; $display("FAIL illegal_f3 lat %0d err %b want lat 1 err 1", lat, e); end
        checks++; if (bus.rd !== 32'h00008000) begin errors++; $display("FAIL err_rd_hold got %h want 00008000", bus.rd); end
    endtask

    task automatic test_back_to_back();
        logic order [4];
        int k, last_done, viol;
        logic busy;
        k = 0; last_done = -10; viol = 0; busy = 1'b0;
        do_reset();
        poke(7'd4, 32'h0000_0004);
        poke(7'd5, 32'h0000_0005);
        bus.funct3_p0 = 3'b010; bus.addr_p0 = 9'h010; bus.we[0] = 1'b0;
        bus.funct3_p1 = 3'b010; bus.addr_p1 = 9'h014; bus.we[1] = 1'b0;
        bus.req = 2'b11;
        for (int cyc = 0; cyc < 40 && k < 4; cyc++) begin
            @(negedge clk);
            if (bus.done != 2'b00) begin last_done = cyc; busy = 1'b0; end
            if (bus.gnt != 2'b00) begin
                if (busy || (k > 0 && cyc != last_done + 1) || bus.gnt == 2'b11) viol++;
                order[k] = bus.gnt[1];
                busy = 1'b1;
                k++;
            end
        end
        @(posedge clk); #1 bus.req = 2'b00;
        repeat (3) @(posedge clk); #1;
        checks++; if (k !== 4) begin errors++; $display("FAIL rr_grant_count got %0d want 4", k); end
        for (int i = 0; i < 4 && i < k; i++) begin
            checks++;
            if (order[i] !== 1'(i % 2)) begin errors++; $display("FAIL rr_order[%0d] got port %0d want port %0d", i, order[i], i % 2); end
        end
        checks++; if (viol !== 0) begin errors++; $display("FAIL rr_grant_spacing violations %0d want 0", viol); end
        checks++; if (bus.rd !== 32'h0000_0005) begin errors++; $display("FAIL rr_last_rd got %h want 00000005", bus.rd); end
    endtask

    task automatic test_reset_mid();
        int w0, viol, gcnt;
        logic g;
        g = 1'b0; viol = 0; gcnt = 0;
        poke(7'd8, 32'h01020304);
        w0 = wr_cnt;
        set_port(0, 1'b1, 3'b000, 9'h020, 32'h00000055);
        for (int i = 0; i < 10 && !g; i++) begin
            @(negedge clk);
            if (bus.gnt[0]) g = 1'b1;
        end
        @(posedge clk); #1 bus.req = 2'b00; rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({bus.gnt, bus.done, bus.err, bus.mem_wr} !== 10'd0 || bus.rd !== 32'd0 ||
            bus.mem_addr !== 32'd0 || bus.mem_wd !== 32'd0 || !g) begin
            errors++;
            $display("FAIL midreset_outputs gnt=%b done=%b err=%b wr=%b rd=%h addr=%h wd=%h granted=%b want zeros granted=1",
                     bus.gnt, bus.done, bus.err, bus.mem_wr, bus.rd, bus.mem_addr, bus.mem_wd, g);
        end
        repeat (3) begin
            @(negedge clk);
            if (bus.done != 2'b00 || bus.mem_wr != 4'h0) viol++;
        end
        @(posedge clk); #1 rst_n = 1'b1;
        checks++; if (viol !== 0 || wr_cnt !== w0 || mem[8] !== 32'h01020304) begin errors++; $display("FAIL midreset_abandon viol %0d writes %0d word %h want 0 0 01020304", viol, wr_cnt - w0, mem[8]); end
        set_port(0, 1'b0, 3'b010, 9'h020, 32'd0);
        set_port(1, 1'b0, 3'b010, 9'h024, 32'd0);
        @(negedge clk);
        checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL midreset_first_gnt got %b want 01", bus.gnt); end
        @(posedge clk); #1 bus.req = 2'b00;
        repeat (4) begin
            @(negedge clk);
            if (bus.gnt != 2'b00) gcnt++;
        end
        checks++; if (gcnt !== 0) begin errors++; $display("FAIL dropped_req_granted count %0d want 0", gcnt); end
        @(posedge clk); #1;
    endtask

    initial begin
        bus.req = 2'b00; bus.we = 2'b00;
        bus.funct3_p0 = '0; bus.funct3_p1 = '0;
        bus.addr_p0 = '0; bus.addr_p1 = '0;
        bus.wd_p0 = '0; bus.wd_p1 = '0;
        test_reset();
        test_lw();
        test_sb();
        test_lanes();
        test_err();
        test_back_to_back();
        test_reset_mid();
        checks++; if (bad_wr !== 0) begin errors++; $display("FAIL partial_strobe count %0d want 0", bad_wr); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
